dmem_lsu_align: RTL
===================

// Module: dmem_lsu_align
// PURPOSE
//  Load/store alignment stage directly upstream of the byte-column data memory (registered read, per-lane write).
//  Accepts byte-addressed LB/LH/LW/SB/SH/SW requests over valid/ready; drives word address, lane enables, shifted
//  write data and spec_ld/valid_st strobes. Extracts and sign/zero-extends load data; splits word-crossing accesses into two.
// PARAMETERS
//  ADDR_WIDTH  10  memory word-address width; byte address is ADDR_WIDTH+2 bits
//  COL_WIDTH   8   lane width (fixed 8); NB_COL 4 lanes (fixed) -> 32-bit data
// PORTS
//  clk             in   1             clock, all state on posedge
//  reset_n         in   1             asynchronous, active-low reset
//  req_valid       in   1             request valid
//  req_ready       out  1             request accepted when valid&ready
//  req_st          in   1             1=store, 0=load
//  req_size        in   2             0=byte,1=half,2=word,3=illegal
//  req_signed      in   1             loads: sign-extend (1) / zero-extend (0)
//  req_addr        in   ADDR_WIDTH+2  byte address
//  req_wdata       in   32            store data, right-justified
//  rsp_valid       out  1             response valid (loads and stores)
//  rsp_ready       in   1             response consumed when valid&ready
//  rsp_rdata       out  32            extended load data; 0 for stores/err
//  rsp_err         out  1             illegal size; no memory access made
//  mem_addr        out  ADDR_WIDTH    word address to memory
//  mem_we          out  4             lane write enables
//  mem_din         out  32            lane-aligned write data
//  mem_spec_ld     out  1             read strobe; dout valid the following cycle
//  mem_valid_st    out  1             write strobe
//  mem_dout        in   32            registered memory read data
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid/rsp_err=0; rsp_rdata=0; mem_* all 0. Mem outputs are combinational from
//   registered state, so assertion of reset_n=0 drops all strobes immediately. Reset mid-split-store may leave only
//   the first word written (accepted).
//  FSM: IDLE -> ACC0 -> [ACC1] -> RSP -> IDLE.
//   IDLE: req_ready=1; on req_valid latch addr/size/st/signed/wdata. size==3 -> RSP with err=1; else -> ACC0.
//   ACC0: mem_addr=addr[ADDR_WIDTH+1:2]; off=addr[1:0]; n=1/2/4 bytes; mask=(1<<n)-1.
//    store: mem_valid_st=1, mem_we=(mask<<off)[3:0], mem_din=wdata<<(8*off). load: mem_spec_ld=1, mem_we=0.
//    split=(off+n>4): -> ACC1, else -> RSP.
//   ACC1: mem_addr=word0+1 mod 2^ADDR_WIDTH (wraps to 0). store: mem_we=mask>>(4-off), mem_din=wdata>>(8*(4-off)).
//    load: mem_spec_ld=1; capture mem_dout (word0) into buffer this cycle. -> RSP.
//   RSP: rsp_valid=1; no mem strobes (mem_dout stays stable). load: rsp_rdata = low n bytes of
//    ({word1,word0}>>(8*off)), word0=buffer if split else mem_dout, word1=mem_dout; extend per req_signed
//    (word: no extension). rsp_rdata/rsp_err held stable while rsp_ready=0; on rsp_ready -> IDLE.
//  req_ready=0 outside IDLE; no overlap. rsp_rdata forced 0 when rsp_valid=0.
//  Latency (accept at edge T): aligned rsp_valid from T+2; split T+3; err T+1. Throughput: 1 per 3 cycles aligned.
//  Only this block drives the memory; spec_ld and valid_st never asserted together.
// TESTING
//  1 SW 0x010,0xDEADBEEF -> ACC0 mem_addr=4 we=1111 din=0xDEADBEEF valid_st=1; rsp_valid T+2 rdata=0; LW 0x010 -> 0xDEADBEEF.
//  2 After 1: LB s 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH s 0x012 -> 0xFFFFDEAD; LHU 0x010 -> 0x0000BEEF.
//  3 SW 0x016,0x11223344 -> ACC0 addr5 we=1100 din=0x33440000; ACC1 addr6 we=0011 din=0x00001122; rsp T+3; LW 0x016 -> 0x11223344.
//  4 SH 0xFFF,0xA55A -> ACC0 addr 0x3FF we=1000 din=0x5A000000; ACC1 addr 0x000 we=0001 din=0x000000A5; LHU 0xFFF -> 0x0000A55A.
//  5 Load held with rsp_ready=0 for 5 cycles -> rsp_valid=1, rsp_rdata stable, req_ready=0, mem strobes 0 throughout.
//  6 size=3 -> rsp_err=1 at T+1, no strobes; reset_n low in ACC1 -> strobes 0 same cycle, IDLE/req_ready=1 after release.

Source files
------------

// File: rtl/dmem_lsu_align.sv
// Load/store alignment stage in front of a 4-lane byte-column data memory with registered read.
// Splits word-crossing accesses into two memory cycles and extends load data.
module dmem_lsu_align #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_st_i,
    input  logic [1:0]              req_size_i,
    input  logic                    req_signed_i,
    input  logic [ADDR_WIDTH+1:0]   req_addr_i,
    input  logic [31:0]             req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [3:0]              mem_we_o,
    output logic [31:0]             mem_din_o,
    output logic                    mem_spec_ld_o,
    output logic                    mem_valid_st_o,
    input  logic [31:0]             mem_dout_i
);

    localparam int unsigned COL_WIDTH = 8;
    localparam int unsigned NB_COL    = 4;
    localparam int unsigned DATA_W    = COL_WIDTH * NB_COL;
    localparam int unsigned BADDR_W   = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RSP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [BADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]           size_q, size_d;
    logic                 st_q, st_d;
    logic                 sgn_q, sgn_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    buf_q, buf_d;

    logic [1:0]             off_c;
    logic [ADDR_WIDTH-1:0]  word0_c;
    logic [ADDR_WIDTH-1:0]  word1_c;
    logic [3:0]             nbytes_c;
    logic [3:0]             mask_c;
    logic [7:0]             mask_sh_c;
    logic [2*DATA_W-1:0]    din_sh_c;
    logic                   split_c;
    logic [DATA_W-1:0]      rd_lo_c;
    logic [DATA_W-1:0]      ld_data_c;

    // Access geometry derived from the latched request
    always_comb begin
        off_c   = addr_q[1:0];
        word0_c = addr_q[BADDR_W-1:2];
        word1_c = ADDR_WIDTH'(word0_c + 1'b1);
        case (size_q)
            2'd0:    begin nbytes_c = 4'd1; mask_c = 4'b0001; end
            2'd1:    begin nbytes_c = 4'd2; mask_c = 4'b0011; end
            2'd2:    begin nbytes_c = 4'd4; mask_c = 4'b1111; end
            default: begin nbytes_c = 4'd0; mask_c = 4'b0000; end
        endcase
        mask_sh_c = 8'({4'b0000, mask_c} << off_c);
        din_sh_c  = (2*DATA_W)'({32'd0, wdata_q} << {off_c, 3'b000});
        split_c   = (4'(off_c) + nbytes_c) > 4'd4;
    end

    // Load data: word0 comes from the capture buffer when split, else straight from memory
    always_comb begin
        rd_lo_c = DATA_W'({mem_dout_i, (split_c ? buf_q : mem_dout_i)} >> {off_c, 3'b000});
        case (size_q)
            2'd0:    ld_data_c = {{24{sgn_q & rd_lo_c[7]}},  rd_lo_c[7:0]};
            2'd1:    ld_data_c = {{16{sgn_q & rd_lo_c[15]}}, rd_lo_c[15:0]};
            default: ld_data_c = rd_lo_c;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            st_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            st_q    <= st_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
        end
    end

    // Next state and state-decoded outputs; memory strobes only in ACC0/ACC1
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        size_d         = size_q;
        st_d           = st_q;
        sgn_d          = sgn_q;
        err_d          = err_q;
        wdata_d        = wdata_q;
        buf_d          = buf_q;
        req_ready_o    = 1'b0;
        rsp_valid_o    = 1'b0;
        rsp_err_o      = 1'b0;
        rsp_rdata_o    = '0;
        mem_addr_o     = '0;
        mem_we_o       = '0;
        mem_din_o      = '0;
        mem_spec_ld_o  = 1'b0;
        mem_valid_st_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    st_d    = req_st_i;
                    sgn_d   = req_signed_i;
                    wdata_d = req_wdata_i;
                    err_d   = (req_size_i == 2'd3);
                    state_d = (req_size_i == 2'd3) ? S_RSP : S_ACC0;
                end
            end
            S_ACC0: begin
                mem_addr_o = word0_c;
                if (st_q) begin
                    mem_valid_st_o = 1'b1;
                    mem_we_o       = mask_sh_c[3:0];
                    mem_din_o      = din_sh_c[DATA_W-1:0];
                end else begin
                    mem_spec_ld_o  = 1'b1;
                end
                state_d = split_c ? S_ACC1 : S_RSP;
            end
            S_ACC1: begin
                mem_addr_o = word1_c;
                if (st_q) begin
                    mem_valid_st_o = 1'b1;
                    mem_we_o       = mask_sh_c[7:4];
                    mem_din_o      = din_sh_c[2*DATA_W-1:DATA_W];
                end else begin
                    mem_spec_ld_o  = 1'b1;
                    buf_d          = mem_dout_i;
                end
                state_d = S_RSP;
            end
            S_RSP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
                if (!st_q && !err_q) begin
                    rsp_rdata_o = ld_data_c;
                end
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
